// File: rtl/ovi_issue_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : ovi_issue_arbiter_if
//  Purpose  : Bundles the requester side, the vector-unit issue/completion
//             side and the halt/status signals of the OVI issue arbiter.
//  Modports : master - requesters / vector-unit model (drives requests,
//                      halt and completions, observes grants and issues)
//             slave  - the arbiter itself
//  Signals  : REQ_VALID/INSTR/VL/SEW (per requester slice), REQ_READY,
//             REQ_DONE, HALT_REQ, HALTED, ISSUE_VALID/INSTR/VL/SEW,
//             COMPL_VALID, OUTSTANDING, ERR
//  Revision : 1.0 - initial release
// ============================================================================
interface ovi_issue_arbiter_if #(
    parameter int NREQ    = 2,
    parameter int MAX_OUT = 4,
    parameter int INSTR_W = 32,
    parameter int VL_W    = 14,
    parameter int SEW_W   = 3
);
    logic [NREQ-1:0]               REQ_VALID;
    logic [NREQ*INSTR_W-1:0]       REQ_INSTR;
    logic [NREQ*VL_W-1:0]          REQ_VL;
    logic [NREQ*SEW_W-1:0]         REQ_SEW;
    logic [NREQ-1:0]               REQ_READY;
    logic [NREQ-1:0]               REQ_DONE;
    logic                          HALT_REQ;
    logic                          HALTED;
    logic                          ISSUE_VALID;
    logic [INSTR_W-1:0]            ISSUE_INSTR;
    logic [VL_W-1:0]               ISSUE_VL;
    logic [SEW_W-1:0]              ISSUE_SEW;
    logic                          COMPL_VALID;
    logic [$clog2(MAX_OUT):0]      OUTSTANDING;
    logic                          ERR;

    modport master (
        output REQ_VALID, REQ_INSTR, REQ_VL, REQ_SEW, HALT_REQ, COMPL_VALID,
        input  REQ_READY, REQ_DONE, HALTED, ISSUE_VALID, ISSUE_INSTR,
               ISSUE_VL, ISSUE_SEW, OUTSTANDING, ERR
    );

    modport slave (
        input  REQ_VALID, REQ_INSTR, REQ_VL, REQ_SEW, HALT_REQ, COMPL_VALID,
        output REQ_READY, REQ_DONE, HALTED, ISSUE_VALID, ISSUE_INSTR,
               ISSUE_VL, ISSUE_SEW, OUTSTANDING, ERR
    );
endinterface
`default_nettype wire

// File: rtl/ovi_issue_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ovi_issue_arbiter
//  Purpose  : Shares the single OVI vector issue port between NREQ sources.
//             Round-robin grant, in-flight cap of MAX_OUT, per-instruction
//             issuer tracking so each in-order completion is routed back to
//             its requester, and a halt/drain sequence.
//  Ports    : CLK  - clock, rising edge
//             RST  - asynchronous reset, active-high
//             bus  - ovi_issue_arbiter_if.slave (requests, grants, done
//                    pulses, issue fields, completions, halt, count, error)
//  Revision : 1.0 - initial release
// ============================================================================
module ovi_issue_arbiter #(
    parameter int NREQ    = 2,
    parameter int MAX_OUT = 4,
    parameter int INSTR_W = 32,
    parameter int VL_W    = 14,
    parameter int SEW_W   = 3
) (
    input  wire logic           CLK,
    input  wire logic           RST,
    ovi_issue_arbiter_if.slave  bus
);
    localparam int c_IDX_W = $clog2(NREQ);
    localparam int c_PTR_W = $clog2(MAX_OUT);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [NREQ-1:0] c_ONE_HOT0 = NREQ'(1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [c_IDX_W-1:0]    r_rr;
    logic [c_CNT_W-1:0]    r_count;
    logic [c_IDX_W-1:0]    r_fifo [MAX_OUT];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [NREQ-1:0]       r_done;
    logic                  r_err;
    logic                  r_issue_valid;
    logic [INSTR_W-1:0]    r_issue_instr;
    logic [VL_W-1:0]       r_issue_vl;
    logic [SEW_W-1:0]      r_issue_sew;

    logic                  w_credit;
    logic                  w_gnt_any;
    logic [c_IDX_W-1:0]    w_gnt_idx;
    logic [c_IDX_W-1:0]    w_cand;
    logic [NREQ-1:0]       w_ready;
    logic                  w_push;
    logic                  w_pop;

    // Count is charged at transfer, so it always equals the ID FIFO occupancy.
    assign w_credit = (r_count < c_CNT_W'(MAX_OUT));
    assign w_push   = w_gnt_any;
    // A completion with nothing in flight is ignored here and flagged as ERR.
    assign w_pop    = bus.COMPL_VALID && (r_count != '0);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and round-robin grant
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_any   = 1'b0;
        w_gnt_idx   = '0;
        w_cand      = '0;
        w_ready     = '0;

        case (r_state)
            ST_RUN:    if (bus.HALT_REQ) w_state_nxt = ST_DRAIN;
            // Nothing charged and no issue still on the bus: drain complete.
            ST_DRAIN:  if ((r_count == '0) && !r_issue_valid) w_state_nxt = ST_HALTED;
            ST_HALTED: if (!bus.HALT_REQ) w_state_nxt = ST_RUN;
            default:   w_state_nxt = ST_RUN;
        endcase

        // HALT_REQ wins over a grant in the same cycle. RST also masks the
        // combinational READY so every output reads 0 while reset is held.
        if ((r_state == ST_RUN) && !bus.HALT_REQ && !RST && w_credit) begin
            // Search starts one past the last winner, wrapping modulo NREQ.
            for (int k = 1; k <= NREQ; k++) begin
                w_cand = c_IDX_W'((int'(r_rr) + k) % NREQ);
                if (!w_gnt_any && bus.REQ_VALID[w_cand]) begin
                    w_gnt_any = 1'b1;
                    w_gnt_idx = w_cand;
                end
            end
        end

        if (w_gnt_any) begin
            w_ready[w_gnt_idx] = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Issue register, credit counter, issuer FIFO, completion routing
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rr          <= c_IDX_W'(NREQ - 1);
            r_count       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_done        <= '0;
            r_err         <= 1'b0;
            r_issue_valid <= 1'b0;
            r_issue_instr <= '0;
            r_issue_vl    <= '0;
            r_issue_sew   <= '0;
            for (int i = 0; i < MAX_OUT; i++) begin
                r_fifo[i] <= '0;
            end
        end else begin
            r_issue_valid <= w_push;
            if (w_push) begin
                r_rr                <= w_gnt_idx;
                r_issue_instr       <= bus.REQ_INSTR[w_gnt_idx*INSTR_W +: INSTR_W];
                r_issue_vl          <= bus.REQ_VL[w_gnt_idx*VL_W +: VL_W];
                r_issue_sew         <= bus.REQ_SEW[w_gnt_idx*SEW_W +: SEW_W];
                r_fifo[r_wr_ptr]    <= w_gnt_idx;
                r_wr_ptr            <= r_wr_ptr + 1'b1;
            end

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_done   <= c_ONE_HOT0 << r_fifo[r_rd_ptr];
            end else begin
                r_done   <= '0;
            end

            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end

            if (bus.COMPL_VALID && (r_count == '0)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.REQ_READY   = w_ready;
    assign bus.REQ_DONE    = r_done;
    assign bus.HALTED      = (r_state == ST_HALTED);
    assign bus.ISSUE_VALID = r_issue_valid;
    assign bus.ISSUE_INSTR = r_issue_instr;
    assign bus.ISSUE_VL    = r_issue_vl;
    assign bus.ISSUE_SEW   = r_issue_sew;
    assign bus.OUTSTANDING = r_count;
    assign bus.ERR         = r_err;

endmodule
`default_nettype wire
